// File: rtl/ram_bist_top.sv
// ram_bist_top: inferred single-port RAM plus a fill/read-back self-test controller.
// Latency: an accepted start gives 2*DEPTH+1 busy cycles, then done; read data q lags addr by one cycle.
// Backpressure: none. start is honoured only in IDLE/DONE, and while busy it is ignored.
// Ports: clk, rst_n (async active-low); start/mode/seed/inject are the test command inputs,
//        latched when start is accepted;
//        busy/done/pass/err_cnt/first_err_addr report status and results; q is raw RAM read data.
module ram_bist_top #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 8,
  parameter int INJ_ADDR = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              mode,
  input  logic [DATA_W-1:0] seed,
  input  logic              inject,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W:0]   err_cnt,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [DATA_W-1:0] q
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] INJ_A = ADDR_W'(INJ_ADDR);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_LAST,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [ADDR_W-1:0] addr;
  logic              mode_l;
  logic [DATA_W-1:0] seed_l;
  logic              inject_l;

  logic              wren;
  logic [DATA_W-1:0] wr_dat;
  logic              accept;
  logic              addr_last;

  // Compare pipeline: expected word and its address trail the presented
  // address by one cycle so they line up with the RAM's registered output.
  logic              cmp_vld;
  logic [DATA_W-1:0] cmp_exp;
  logic [ADDR_W-1:0] cmp_addr;

  logic [DATA_W-1:0] mem [DEPTH];

  // Address is zero-extended or truncated to the word width, then offset by seed.
  function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] a,
                                                input logic              m,
                                                input logic [DATA_W-1:0] s);
    logic [DATA_W-1:0] p;
    p = DATA_W'(a) + s;
    return m ? ~p : p;
  endfunction

  assign addr_last = &addr;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    wren      = 1'b0;
    wr_dat    = pattern(addr, mode_l, seed_l);
    accept    = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = S_WRITE;
        end
      end
      S_WRITE: begin
        wren = 1'b1;
        // Planted fault so the checker's error path can be exercised on the board.
        if (inject_l && (addr == INJ_A)) begin
          wr_dat = wr_dat ^ DATA_W'(1);
        end
        if (addr_last) begin
          state_nxt = S_READ;
        end
      end
      S_READ: begin
        if (addr_last) begin
          state_nxt = S_LAST;
        end
      end
      S_LAST: begin
        state_nxt = S_DONE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  assign busy = (state == S_WRITE) || (state == S_READ) || (state == S_LAST);
  assign done = (state == S_DONE);
  assign pass = (state == S_DONE) && (err_cnt == '0);

  // ----------------------------------------------------------- datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr           <= '0;
      mode_l         <= 1'b0;
      seed_l         <= '0;
      inject_l       <= 1'b0;
      cmp_vld        <= 1'b0;
      cmp_exp        <= '0;
      cmp_addr       <= '0;
      err_cnt        <= '0;
      first_err_addr <= '0;
    end else begin
      cmp_vld  <= (state == S_READ);
      cmp_exp  <= pattern(addr, mode_l, seed_l);
      cmp_addr <= addr;
      if (accept) begin
        addr           <= '0;
        err_cnt        <= '0;
        first_err_addr <= '0;
        mode_l         <= mode;
        seed_l         <= seed;
        inject_l       <= inject;
      end else begin
        // Natural wrap at DEPTH-1 returns addr to 0 for the read pass.
        if ((state == S_WRITE) || (state == S_READ)) begin
          addr <= addr + ADDR_W'(1);
        end
        // cmp_vld is never set in the accept cycle, so clearing above cannot collide.
        if (cmp_vld && (q != cmp_exp)) begin
          err_cnt <= err_cnt + CNT_W'(1);
          if (err_cnt == '0) begin
            first_err_addr <= cmp_addr;
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------- RAM
  // No reset on the array or its output register so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wren) begin
      mem[addr] <= wr_dat;
    end
    q <= mem[addr];
  end

endmodule

// File: doc/ram_bist_top.md
Name: ram_bist_top

Overview:
- Parametrised successor to the team's fixed 8-bit RAM demo.
- Contains an inferred single-port synchronous RAM, 2^ADDR_W x DATA_W, plus a built-in self-test controller.
- On command, the controller fills the whole RAM with a selectable pattern, reads it back, and compares every word.
- Reports pass/fail, error count and first failing address; it is the bring-up memory check on the DE2-115 board.

Parameters:
DATA_W, 8, RAM word width in bits (1..32)
ADDR_W, 8, address width; DEPTH = 2^ADDR_W words
INJ_ADDR, 5, address whose written word gets bit 0 inverted when injection is armed (must be < DEPTH)

Ports:
clk  in  1  system clock; all logic on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  begin a test; sampled only in IDLE or DONE
mode  in  1  pattern select, latched with start: 0 = incrementing, 1 = inverted incrementing
seed  in  DATA_W  pattern offset, latched with start
inject  in  1  arm error injection, latched with start
busy  out  1  high in WRITE, READ and LAST
done  out  1  high in DONE until the next accepted start
pass  out  1  valid while done; 1 when err_cnt == 0
err_cnt  out  ADDR_W+1  number of mismatching words in the last test
first_err_addr  out  ADDR_W  address of the first mismatch; 0 if none
q  out  DATA_W  raw RAM read data, for debug

Behaviour:
- Reset (async assert, sync release): FSM to IDLE; addr, err_cnt, first_err_addr, latched mode/seed/inject all 0; busy, done, pass = 0. RAM contents are not reset.
- Pattern: P(a) = (zero-extend or truncate a to DATA_W) + seed, mod 2^DATA_W; if mode = 1 it is ~P(a).
- RAM: synchronous write when wren = 1. Synchronous read: q(t+1) = mem[addr(t)]. Read-during-write returns old data; it is never exercised by the FSM.
- FSM states: IDLE, WRITE, READ, LAST, DONE.
- IDLE/DONE:
  - start = 1 -> WRITE.
  - On that edge: addr <= 0; err_cnt <= 0; first_err_addr <= 0; done <= 0; latch mode, seed and inject.
- WRITE:
  - wren = 1, data = P(addr).
  - If addr == INJ_ADDR and latched inject = 1, data = P(addr) with bit 0 inverted.
  - addr increments each cycle. At addr == DEPTH-1, wrap addr to 0 and go to READ.
- READ:
  - wren = 0; present addr, increment each cycle.
  - A registered compare-valid flag and expected value (P(addr)) follow one cycle behind to match RAM latency.
  - At addr == DEPTH-1 go to LAST.
- LAST: one cycle; performs the final comparison for address DEPTH-1; then -> DONE.
- Compare, in the cycle after an address was presented:
  - If q != expected, err_cnt increments.
  - If err_cnt was 0 before the increment, first_err_addr <= that address.
  - err_cnt cannot overflow (maximum DEPTH fits in ADDR_W+1 bits).
- DONE: done = 1, busy = 0, pass = (err_cnt == 0). err_cnt and first_err_addr hold.
- Latency: with start sampled at edge 0, WRITE covers cycles 1..DEPTH, READ covers DEPTH+1..2·DEPTH, LAST is cycle 2·DEPTH+1, and done is high from cycle 2·DEPTH+2.
- start while busy: ignored; the in-flight test is unaffected.
- start held high in DONE: restarts immediately. Back-to-back tests are legal.
- mode, seed, inject changes while busy: no effect until the next accepted start.
- Reset mid-test: immediate return to reset state; the partially written RAM is left as is. The next test overwrites every word before reading, so stale contents never affect the result.
- DATA_W < ADDR_W: the pattern aliases across addresses. This is legal; checking stays exact.

Test Plan:
- Defaults, mode=0, seed=0x00, inject=0, start pulse -> busy for 513 cycles; done at cycle 514; pass=1; err_cnt=0; first_err_addr=0; mem[0x37] reads 0x37.
- mode=1, seed=0x10 -> mem[0x00]=0xEF and mem[0xFF]=0xF0 (wraps); pass=1.
- inject=1, seed=0 -> err_cnt=1, first_err_addr=0x05, pass=0; q observed 0x04 during the read-back of address 5.
- Reset asserted at cycle 100 of WRITE, then a new start -> outputs zero during reset; second test completes with pass=1 at cycle 514 from its start.
- start pulsed again at cycle 50 of the READ phase -> ignored, done timing unchanged; start held high through DONE -> new test begins the next cycle, done drops, busy rises.
- DATA_W=4, ADDR_W=3, seed=0xE -> DEPTH=8; mem[2]=0x0 (wrap); done at cycle 18; pass=1.
